link_frame_rx: RTL and testbench

- Byte-level frame parser between the UART receiver and game logic on the peer link.
- Turns the raw byte stream from the other board into a decoded remote direction (dir2 / rcvdir), a remote point seed, and the start_game request.
- Supervises link health and drives the con_error input of mode control, which is currently tied off.
- Sits directly upstream of move, generate_point and mode_control.

---
 rtl/snake_pkg.sv | 27 ++
 rtl/link_watchdog.sv | 52 +++++
 rtl/link_frame_rx.sv | 152 +++++++++++++++
 tb/tb_link_frame_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and link-protocol constants for the snake game blocks.
package snake_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      RIGHT = 2'd1,
      DOWN  = 2'd2,
      LEFT  = 2'd3
   } direction;

   typedef enum logic [1:0] {
      MENU      = 2'd0,
      GAME      = 2'd1,
      GAME_OVER = 2'd2
   } game_mode;

   localparam logic [7:0] HEADER      = 8'hA5;
   localparam logic [7:0] FRAME_DIR   = 8'h01;
   localparam logic [7:0] FRAME_SEED  = 8'h02;
   localparam logic [7:0] FRAME_START = 8'h03;

   localparam int unsigned BYTE_TIMEOUT       = 75000;
   localparam int unsigned LINK_TIMEOUT_TICKS = 4;
   localparam int unsigned CNT_W              = 17;
   localparam int unsigned MISS_W             = 3;

endpackage

// File: rtl/link_watchdog.sv
// Peer-link health monitor: counts game ticks without a committed DIR frame
// and raises a sticky con_error, cleared by a START commit.
module link_watchdog
   import snake_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     tick,
   input  game_mode mode,
   input  logic     dir_commit,
   input  logic     rx_err,
   input  logic     start_commit,
   output logic     con_error
);

   logic              tick_q;
   logic              tick_edge;
   logic [MISS_W-1:0] miss_cnt;
   logic [MISS_W-1:0] miss_d;
   logic              con_error_d;
   logic              in_game;
   logic              miss_set;

   // The counter saturates at the limit so the error fires once per miss run.
   always_comb begin
      tick_edge   = tick & ~tick_q;
      in_game     = (mode == GAME);
      miss_d      = miss_cnt;
      miss_set    = 1'b0;
      if (!in_game || dir_commit) begin
         miss_d = '0;
      end else if (tick_edge && (miss_cnt != MISS_W'(LINK_TIMEOUT_TICKS))) begin
         miss_d   = miss_cnt + MISS_W'(1);
         miss_set = (miss_d == MISS_W'(LINK_TIMEOUT_TICKS));
      end
      con_error_d = con_error | miss_set | (in_game & rx_err);
      if (start_commit) con_error_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_q    <= 1'b0;
         miss_cnt  <= '0;
         con_error <= 1'b0;
      end else begin
         tick_q    <= tick;
         miss_cnt  <= miss_d;
         con_error <= con_error_d;
      end
   end

endmodule

// File: rtl/link_frame_rx.sv
// Byte-stream frame parser for the peer link: decodes DIR, SEED and START
// frames, counts rejected frames and feeds the link watchdog.
module link_frame_rx
   import snake_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_err,
   input  logic       tick,
   input  game_mode   mode,
   output direction   dir2,
   output logic       rcvdir,
   output logic [4:0] seed_x_out,
   output logic [4:0] seed_y_out,
   output logic       seed_valid,
   output logic       start_game,
   output logic       con_error,
   output logic [7:0] bad_frames
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_TYPE = 3'd1;
   localparam logic [2:0] S_PAY0 = 3'd2;
   localparam logic [2:0] S_PAY1 = 3'd3;
   localparam logic [2:0] S_CHK  = 3'd4;

   logic [2:0]       state, state_d;
   logic [7:0]       frame_type, type_d;
   logic [7:0]       pay0, pay0_d;
   logic [7:0]       pay1, pay1_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [7:0]       chk_calc;
   logic             rsv_ok;
   logic             bad_hit;
   logic             dir_commit, seed_commit, start_commit;
   direction         dir_d;
   logic [4:0]       seed_x_d, seed_y_d;
   logic [7:0]       bad_d;

   always_comb begin
      state_d      = state;
      type_d       = frame_type;
      pay0_d       = pay0;
      pay1_d       = pay1;
      cnt_d        = (state == S_IDLE) ? '0 : cnt + CNT_W'(1);
      bad_hit      = 1'b0;
      dir_commit   = 1'b0;
      seed_commit  = 1'b0;
      start_commit = 1'b0;
      chk_calc     = frame_type ^ pay0 ^ pay1;
      if (frame_type == FRAME_DIR)       rsv_ok = (pay0[7:2] == 6'd0);
      else if (frame_type == FRAME_SEED) rsv_ok = (pay0[7:5] == 3'd0) && (pay1[7:5] == 3'd0);
      else                               rsv_ok = 1'b1;

      // Abort sources take priority over a byte arriving in the same cycle.
      if ((state != S_IDLE) && rx_err) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         bad_hit = 1'b1;
      end else if (rx_valid) begin
         cnt_d = '0;
         case (state)
            S_IDLE: if (rx_data == HEADER) state_d = S_TYPE;
            S_TYPE: begin
               type_d = rx_data;
               pay0_d = 8'd0;
               pay1_d = 8'd0;
               if ((rx_data == FRAME_DIR) || (rx_data == FRAME_SEED)) begin
                  state_d = S_PAY0;
               end else if (rx_data == FRAME_START) begin
                  state_d = S_CHK;
               end else begin
                  state_d = S_IDLE;
                  bad_hit = 1'b1;
               end
            end
            S_PAY0: begin
               pay0_d  = rx_data;
               state_d = (frame_type == FRAME_SEED) ? S_PAY1 : S_CHK;
            end
            S_PAY1: begin
               pay1_d  = rx_data;
               state_d = S_CHK;
            end
            S_CHK: begin
               state_d = S_IDLE;
               if ((rx_data == chk_calc) && rsv_ok) begin
                  dir_commit   = (frame_type == FRAME_DIR);
                  seed_commit  = (frame_type == FRAME_SEED);
                  start_commit = (frame_type == FRAME_START);
               end else begin
                  bad_hit = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else if ((state != S_IDLE) && (cnt == CNT_W'(BYTE_TIMEOUT))) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         bad_hit = 1'b1;
      end

      dir_d    = dir_commit  ? direction'(pay0[1:0]) : dir2;
      seed_x_d = seed_commit ? pay0[4:0] : seed_x_out;
      seed_y_d = seed_commit ? pay1[4:0] : seed_y_out;
      bad_d    = (bad_hit && (bad_frames != 8'hFF)) ? bad_frames + 8'd1 : bad_frames;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         frame_type <= 8'd0;
         pay0       <= 8'd0;
         pay1       <= 8'd0;
         cnt        <= '0;
         dir2       <= UP;
         rcvdir     <= 1'b0;
         seed_x_out <= 5'd0;
         seed_y_out <= 5'd0;
         seed_valid <= 1'b0;
         start_game <= 1'b0;
         bad_frames <= 8'd0;
      end else begin
         state      <= state_d;
         frame_type <= type_d;
         pay0       <= pay0_d;
         pay1       <= pay1_d;
         cnt        <= cnt_d;
         dir2       <= dir_d;
         rcvdir     <= dir_commit;
         seed_x_out <= seed_x_d;
         seed_y_out <= seed_y_d;
         seed_valid <= seed_commit;
         start_game <= start_commit;
         bad_frames <= bad_d;
      end
   end

   link_watchdog u_watchdog (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .mode         (mode),
      .dir_commit   (dir_commit),
      .rx_err       (rx_err),
      .start_commit (start_commit),
      .con_error    (con_error)
   );

endmodule

// File: tb/tb_link_frame_rx.sv
// Directed bench for link_frame_rx: a frame-level reference model checked
// every cycle, plus literal expectations at key points.
module tb_link_frame_rx;
   import snake_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_data = 8'd0;
   logic       rx_valid = 1'b0;
   logic       rx_err = 1'b0;
   logic       tick = 1'b0;
   game_mode   mode = MENU;
   direction   dir2;
   logic       rcvdir, seed_valid, start_game, con_error;
   logic [4:0] seed_x_out, seed_y_out;
   logic [7:0] bad_frames;

   int checks = 0;
   int failures = 0;

   link_frame_rx dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_err     (rx_err),
      .tick       (tick),
      .mode       (mode),
      .dir2       (dir2),
      .rcvdir     (rcvdir),
      .seed_x_out (seed_x_out),
      .seed_y_out (seed_y_out),
      .seed_valid (seed_valid),
      .start_game (start_game),
      .con_error  (con_error),
      .bad_frames (bad_frames)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: frame bytes are collected in a queue and judged as a
   // whole once the length implied by the TYPE byte has arrived.
   logic [7:0] fb[$];
   int  gap = 0;
   int  e_dir = 0, e_sx = 0, e_sy = 0, e_bad = 0, miss = 0;
   bit  e_rcv = 0, e_sv = 0, e_start = 0, e_con = 0, tprev = 0;
   bit  dc, sc, tedge, ok;
   int  need;
   logic [7:0] x;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         fb.delete();
         gap = 0; e_dir = 0; e_sx = 0; e_sy = 0; e_bad = 0; miss = 0;
         e_rcv = 0; e_sv = 0; e_start = 0; e_con = 0; tprev = 0;
      end else begin
         e_rcv = 0; e_sv = 0; e_start = 0; dc = 0; sc = 0;
         if (rx_err && fb.size() != 0) begin
            fb.delete();
            if (e_bad < 255) e_bad++;
         end else if (rx_valid) begin
            gap = 0;
            if (fb.size() != 0 || rx_data == 8'hA5) fb.push_back(rx_data);
            if (fb.size() == 2 && !(fb[1] inside {8'h01, 8'h02, 8'h03})) begin
               fb.delete();
               if (e_bad < 255) e_bad++;
            end else if (fb.size() >= 2) begin
               need = (fb[1] == 8'h01) ? 4 : (fb[1] == 8'h02) ? 5 : 3;
               if (fb.size() == need) begin
                  x = 8'h00;
                  for (int i = 1; i < need - 1; i++) x ^= fb[i];
                  ok = (x == fb[need-1]);
                  if (fb[1] == 8'h01) ok = ok && ((fb[2] & 8'hFC) == 0);
                  if (fb[1] == 8'h02) ok = ok && ((fb[2] & 8'hE0) == 0) && ((fb[3] & 8'hE0) == 0);
                  if (!ok) begin
                     if (e_bad < 255) e_bad++;
                  end else if (fb[1] == 8'h01) begin
                     e_dir = int'(fb[2] & 8'h03); e_rcv = 1; dc = 1;
                  end else if (fb[1] == 8'h02) begin
                     e_sx = int'(fb[2]); e_sy = int'(fb[3]); e_sv = 1;
                  end else begin
                     e_start = 1; sc = 1;
                  end
                  fb.delete();
               end
            end
         end else if (fb.size() != 0) begin
            if (gap == BYTE_TIMEOUT) begin
               fb.delete();
               gap = 0;
               if (e_bad < 255) e_bad++;
            end else gap++;
         end
         tedge = tick && !tprev;
         tprev = tick;
         if (mode != GAME || dc) miss = 0;
         else if (tedge && miss < 4) begin
            miss++;
            if (miss == 4) e_con = 1;
         end
         if (mode == GAME && rx_err) e_con = 1;
         if (sc) e_con = 0;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         check("dir2", int'(dir2), e_dir);
         check("rcvdir", int'(rcvdir), int'(e_rcv));
         check("seed_x", int'(seed_x_out), e_sx);
         check("seed_y", int'(seed_y_out), e_sy);
         check("seed_valid", int'(seed_valid), int'(e_sv));
         check("start_game", int'(start_game), int'(e_start));
         check("con_error", int'(con_error), int'(e_con));
         check("bad_frames", int'(bad_frames), e_bad);
      end
   end

   task automatic send(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick_pulse();
      tick = 1'b1; idle(2);
      tick = 1'b0; idle(2);
   endtask

   initial begin
      idle(3);
      check("rst_dir2", int'(dir2), 0);
      check("rst_bad", int'(bad_frames), 0);
      check("rst_con", int'(con_error), 0);
      rst = 1'b1;
      idle(2);

      send(8'h33); send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
      check("dir_val", int'(dir2), 2);
      check("dir_pulse", int'(rcvdir), 1);
      idle(1);
      check("dir_pulse_end", int'(rcvdir), 0);
      check("dir_bad", int'(bad_frames), 0);

      send(8'hA5); send(8'h02); send(8'h11); send(8'h07); send(8'h14);
      check("seed_x_lit", int'(seed_x_out), 5'h11);
      check("seed_y_lit", int'(seed_y_out), 5'h07);
      check("seed_pulse", int'(seed_valid), 1);
      idle(2);
      send(8'hA5); send(8'h02); send(8'h03); send(8'h04); send(8'h15);
      check("badchk_x", int'(seed_x_out), 5'h11);
      check("badchk_bad", int'(bad_frames), 1);

      send(8'hA5); send(8'h09);
      idle(1);
      check("badtype_bad", int'(bad_frames), 2);
      send(8'hA5); send(8'h03); send(8'h03);
      check("start_pulse", int'(start_game), 1);
      idle(1);
      check("start_pulse_end", int'(start_game), 0);

      send(8'hA5); send(8'h01);
      idle(74000);
      check("timeout_early", int'(bad_frames), 2);
      idle(1010);
      check("timeout_bad", int'(bad_frames), 3);
      check("timeout_dir", int'(dir2), 2);

      send(8'hA5); send(8'h01); send(8'h06); send(8'h07);
      check("rsv_bad", int'(bad_frames), 4);
      check("rsv_dir", int'(dir2), 2);

      mode = GAME;
      idle(1);
      repeat (3) tick_pulse();
      check("wd_3edges", int'(con_error), 0);
      tick_pulse();
      check("wd_4edges", int'(con_error), 1);
      send(8'hA5); send(8'h03); send(8'h03);
      check("wd_start", int'(start_game), 1);
      check("wd_clear", int'(con_error), 0);
      idle(3);
      check("wd_stay_clear", int'(con_error), 0);

      send(8'hA5); send(8'h01); send(8'h01); send(8'h00);
      repeat (3) tick_pulse();
      send(8'hA5); send(8'h01); send(8'h03);
      rx_data = 8'h02; rx_valid = 1'b1; tick = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      check("race_dir", int'(dir2), 3);
      check("race_con", int'(con_error), 0);
      idle(1); tick = 1'b0; idle(2);
      repeat (3) tick_pulse();
      check("race_miss_zero", int'(con_error), 0);
      rx_err = 1'b1; idle(1); rx_err = 1'b0;
      check("rxerr_con", int'(con_error), 1);
      check("rxerr_idle_bad", int'(bad_frames), 4);

      mode = MENU;
      repeat (260) begin send(8'hA5); send(8'hFF); end
      check("bad_sat", int'(bad_frames), 255);

      send(8'hA5); send(8'h02); send(8'h0A);
      rst = 1'b0;
      #1;
      check("mid_rst_dir", int'(dir2), 0);
      check("mid_rst_seed", int'(seed_x_out), 0);
      check("mid_rst_bad", int'(bad_frames), 0);
      check("mid_rst_con", int'(con_error), 0);
      idle(2);
      rst = 1'b1;
      idle(1);
      send(8'hA5); send(8'h01); send(8'h03); send(8'h02);
      check("post_rst_dir", int'(dir2), 3);
      check("post_rst_pulse", int'(rcvdir), 1);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
